// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers. It runs a fixed-latency handshake:
// 5 busy cycles for mult/multu and 10 for div/divu.
module mdu (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [31:0] A_i,
  input  logic [31:0] B_i,
  input  logic [2:0]  MDop_i,
  output logic        start_o,
  output logic        busy_o,
  output logic [31:0] HI_o,
  output logic [31:0] LO_o
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] hi, lo, hi_nxt, lo_nxt;
  logic [63:0] prod;
  logic [31:0] a_mag, b_mag, b_safe, uq, ur;
  logic        a_neg, b_neg;
  logic [31:0] res_hi, res_lo;
  logic        res_ok;

  assign busy_o  = (state == BUSY);
  assign start_o = rstn_i & ~busy_o & (MDop_i >= OP_MULT) & (MDop_i <= OP_DIVU);
  assign HI_o    = hi;
  assign LO_o    = lo;

  // Result datapath from the captured operands.
  // Division goes through magnitudes so that 0x80000000 / -1 wraps cleanly.
  always_comb begin
    prod   = 64'd0;
    res_hi = 32'd0;
    res_lo = 32'd0;
    res_ok = 1'b0;
    a_neg  = (op_q == OP_DIV) & a_q[31];
    b_neg  = (op_q == OP_DIV) & b_q[31];
    a_mag  = a_neg ? (32'd0 - a_q) : a_q;
    b_mag  = b_neg ? (32'd0 - b_q) : b_q;
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    uq     = a_mag / b_safe;
    ur     = a_mag % b_safe;
    case (op_q)
      OP_MULT: begin
        prod   = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        res_ok = 1'b1;
      end
      OP_MULTU: begin
        prod   = {32'd0, a_q} * {32'd0, b_q};
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        res_ok = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        res_lo = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
        res_hi = a_neg ? (32'd0 - ur) : ur;
        res_ok = (b_q != 32'd0);
      end
      default: begin
        res_ok = 1'b0;
      end
    endcase
  end

  // Next-state, counter and HI/LO update logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hi_nxt    = hi;
    lo_nxt    = lo;
    case (state)
      IDLE: begin
        if (start_o) begin
          state_nxt = BUSY;
          cnt_nxt   = ((MDop_i == OP_MULT) || (MDop_i == OP_MULTU)) ? 4'd5 : 4'd10;
        end else if (MDop_i == OP_MTHI) begin
          hi_nxt = A_i;
        end else if (MDop_i == OP_MTLO) begin
          lo_nxt = A_i;
        end else begin
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (cnt == 4'd1) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
          if (res_ok) begin
            hi_nxt = res_hi;
            lo_nxt = res_lo;
          end else begin
            hi_nxt = hi;
            lo_nxt = lo;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // State, counter and architectural HI/LO registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= IDLE;
      cnt   <= 4'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
    end
  end

  // Operand capture, which happens only when an operation is accepted.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      op_q <= 3'd0;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
    end else if (start_o) begin
      op_q <= MDop_i;
      a_q  <= A_i;
      b_q  <= B_i;
    end else begin
      op_q <= op_q;
      a_q  <= a_q;
      b_q  <= b_q;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases plus randomized ops.
// Expected values come from a 64-bit arithmetic reference model.
module tb_mdu;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] A, B;
  logic [2:0]  MDop;
  logic        start, busy;
  logic [31:0] HI, LO;

  int total = 0;
  int bad   = 0;
  logic [31:0] cur_hi = 32'd0;
  logic [31:0] cur_lo = 32'd0;

  mdu dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .A_i    (A),
    .B_i    (B),
    .MDop_i (MDop),
    .start_o(start),
    .busy_o (busy),
    .HI_o   (HI),
    .LO_o   (LO)
  );

  always #5 clk = ~clk;

  function automatic void ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] ohi, input logic [31:0] olo,
                                    output logic [31:0] nhi, output logic [31:0] nlo);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0] v, w;
    nhi = ohi;
    nlo = olo;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd1: begin v = sa * sb; nhi = v[63:32]; nlo = v[31:0]; end
      3'd2: begin v = ua * ub; nhi = v[63:32]; nlo = v[31:0]; end
      3'd3: if (b != 32'd0) begin q = sa / sb; r = sa % sb; v = q; w = r; nlo = v[31:0]; nhi = w[31:0]; end
      3'd4: if (b != 32'd0) begin v = ua / ub; w = ua % ub; nlo = v[31:0]; nhi = w[31:0]; end
      3'd5: nhi = a;
      3'd6: nlo = a;
      default: ;
    endcase
  endfunction

  // Called just after a falling edge in an idle cycle.
  // On return it is again just after a falling edge, in the first idle cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string nm);
    logic [31:0] nh, nl;
    int n;
    MDop = op; A = a; B = b;
    #1;
    total++;
    if (start !== 1'b1) begin bad++; $display("FAIL %s start: got %b want 1", nm, start); end
    ref_model(op, a, b, cur_hi, cur_lo, nh, nl);
    @(posedge clk);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      n++;
      total++;
      if (HI !== cur_hi || LO !== cur_lo) begin
        bad++; $display("FAIL %s hold: got %h_%h want %h_%h", nm, HI, LO, cur_hi, cur_lo);
      end
      MDop = 3'($urandom_range(1, 6)); A = $urandom; B = $urandom;
      #1;
      total++;
      if (start !== 1'b0) begin bad++; $display("FAIL %s start_busy: got %b want 0", nm, start); end
    end
    MDop = 3'd0;
    total++;
    if (n != ((op <= 3'd2) ? 5 : 10)) begin
      bad++; $display("FAIL %s busy_len: got %0d want %0d", nm, n, (op <= 3'd2) ? 5 : 10);
    end
    total++;
    if (HI !== nh || LO !== nl) begin
      bad++; $display("FAIL %s result: got %h_%h want %h_%h", nm, HI, LO, nh, nl);
    end
    cur_hi = nh;
    cur_lo = nl;
  endtask

  task automatic do_mt(input logic [2:0] op, input logic [31:0] a, input string nm);
    @(negedge clk);
    MDop = op; A = a;
    #1;
    total++;
    if (start !== 1'b0) begin bad++; $display("FAIL %s start: got %b want 0", nm, start); end
    @(negedge clk);
    MDop = 3'd0;
    if (op == 3'd5) cur_hi = a; else cur_lo = a;
    total++;
    if (HI !== cur_hi || LO !== cur_lo) begin
      bad++; $display("FAIL %s write: got %h_%h want %h_%h", nm, HI, LO, cur_hi, cur_lo);
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0; MDop = 3'd1; A = $urandom; B = $urandom;
    #3;
    total++;
    if (start !== 1'b0 || busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      bad++; $display("FAIL reset: got start=%b busy=%b hi=%h lo=%h want 0", start, busy, HI, LO);
    end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1; MDop = 3'd0;
  endtask

  task automatic test_directed;
    @(negedge clk);
    run_op(3'd1, 32'hFFFFFFFD, 32'd7, "mult_neg");
    total++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFEB) begin
      bad++; $display("FAIL mult_const: got %h_%h want ffffffff_ffffffeb", HI, LO);
    end
    @(negedge clk);
    run_op(3'd2, 32'hFFFFFFFF, 32'd2, "multu");
    total++;
    if (HI !== 32'h00000001 || LO !== 32'hFFFFFFFE) begin
      bad++; $display("FAIL multu_const: got %h_%h want 00000001_fffffffe", HI, LO);
    end
    @(negedge clk);
    run_op(3'd3, 32'hFFFFFFF9, 32'd2, "div_neg");
    total++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD) begin
      bad++; $display("FAIL div_const: got %h_%h want ffffffff_fffffffd", HI, LO);
    end
    @(negedge clk);
    run_op(3'd4, 32'd1234, 32'd0, "divu_zero");
    @(negedge clk);
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    total++;
    if (HI !== 32'h00000000 || LO !== 32'h80000000) begin
      bad++; $display("FAIL div_ovf_const: got %h_%h want 00000000_80000000", HI, LO);
    end
    do_mt(3'd5, 32'h12345678, "mthi");
    do_mt(3'd6, 32'h9ABCDEF0, "mtlo");
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    run_op(3'd1, 32'd300, 32'hFFFFFF00, "b2b_mult");
    run_op(3'd2, 32'hDEADBEEF, 32'h0000F00D, "b2b_multu");
    run_op(3'd4, 32'hFFFF0000, 32'd3, "b2b_divu");
  endtask

  task automatic test_random;
    logic [2:0] op;
    logic [31:0] a, b;
    for (int k = 0; k < 30; k++) begin
      op = 3'($urandom_range(1, 6));
      a = $urandom; b = $urandom;
      if (op >= 3'd3 && op <= 3'd4 && $urandom_range(0, 3) == 0) b = 32'd0;
      if (op >= 3'd3 && op <= 3'd4 && $urandom_range(0, 3) == 0) b = b >> $urandom_range(4, 28);
      if (op >= 3'd5) begin
        do_mt(op, a, "rnd_mt");
      end else begin
        @(negedge clk);
        run_op(op, a, b, "rnd_op");
      end
    end
  endtask

  task automatic test_reset_mid;
    int n;
    do_mt(3'd5, 32'hCAFEF00D, "pre_hi");
    do_mt(3'd6, 32'h0BADBEEF, "pre_lo");
    @(negedge clk);
    MDop = 3'd3; A = 32'd100; B = 32'd7;
    @(posedge clk);
    #1 MDop = 3'd0;
    n = 0;
    for (int i = 0; i < 20 && n < 4; i++) begin
      @(negedge clk);
      if (busy === 1'b1) n++;
    end
    #2 rstn = 1'b0; MDop = 3'd3;
    #1;
    total++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0 || start !== 1'b0) begin
      bad++; $display("FAIL reset_mid: got busy=%b start=%b hi=%h lo=%h want 0", busy, start, HI, LO);
    end
    @(negedge clk);
    rstn = 1'b1; MDop = 3'd0;
    cur_hi = 32'd0; cur_lo = 32'd0;
    repeat (12) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
        bad++; $display("FAIL post_reset: got busy=%b hi=%h lo=%h want 0", busy, HI, LO);
      end
    end
    @(negedge clk);
    run_op(3'd2, 32'd6, 32'd7, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
